if_stage_pipe: RTL and testbench
================================

Name: if_stage_pipe

Overview:
Parametrised instruction-fetch stage for the pipelined RISC-V CPU. It merges the PC register, the PC+step adder and the IF/ID pipeline register into one block. It adds stall, flush, branch redirect, a valid bit and a saturating fetch counter. It drives the instruction-memory address and presents a registered instruction/PC pair to the decode stage.

Parameters:
XLEN, 32, width of PC and instruction datapath
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per fetch; power of two
NOP_INSTR, 32'h00000013, instruction word inserted as a bubble (addi x0,x0,0)
CNT_W, 16, width of fetch counter

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset; one clock, synchronous, active-high
start_i  input  1  fetch enable; low freezes the PC and injects bubbles
stall_i  input  1  decode-stage hazard stall; holds PC and IF/ID
flush_i  input  1  squash the IF/ID contents (insert bubble)
redirect_i  input  1  taken branch/jump; load redirect_pc_i into PC and squash IF/ID
redirect_pc_i  input  XLEN  redirect target
imem_addr_o  output  XLEN  instruction-memory address (= current PC, combinational from PC register)
imem_instr_i  input  XLEN  instruction word for imem_addr_o, same cycle (combinational memory)
pc_o  output  XLEN  current PC register
id_pc_o  output  XLEN  PC of the instruction held in IF/ID
id_instr_o  output  XLEN  instruction held in IF/ID
id_valid_o  output  1  IF/ID holds a real instruction
fetch_cnt_o  output  CNT_W  count of instructions captured into IF/ID

Behaviour:
- Reset (rst_i=1 at an edge) overrides everything:
  - pc=RESET_PC, id_pc_o=0, id_instr_o=NOP_INSTR, id_valid_o=0, fetch_cnt_o=0.
  - imem_addr_o=pc_o=RESET_PC from the following cycle.
- PC next-value priority, highest first:
  - rst_i -> RESET_PC
  - redirect_i -> redirect_pc_i with the low log2(PC_STEP) bits forced to 0
  - stall_i -> hold
  - !start_i -> hold
  - otherwise -> pc+PC_STEP, modulo 2^XLEN; wraps from all-ones-aligned to 0 with no flag.
- IF/ID next-value priority, highest first:
  - rst_i -> bubble
  - flush_i or redirect_i -> bubble (id_instr_o=NOP_INSTR, id_valid_o=0, id_pc_o=0)
  - stall_i -> hold all three fields
  - !start_i -> bubble
  - otherwise -> capture id_instr_o=imem_instr_i, id_pc_o=pc, id_valid_o=1.
- Simultaneous events:
  - redirect_i with stall_i: redirect wins for both PC and IF/ID.
  - flush_i with stall_i: IF/ID takes a bubble; PC holds.
  - flush_i alone does not change the PC path.
- Latency:
  - An instruction at address A appears on id_instr_o one cycle after pc_o=A with no stall.
  - After a redirect edge, the target instruction reaches IF/ID at the second edge; exactly one bubble is inserted.
- fetch_cnt_o increments by 1 on every edge where IF/ID captures (the "otherwise" case). It saturates at 2^CNT_W-1; stall, bubble and reset cases never increment it.
- Outputs are registered, except imem_addr_o, which is a wire copy of pc_o. There are no combinational paths from inputs to outputs.
- Reset in the middle of a stall or redirect fully discards pending state; nothing survives reset.

Test Plan:
- Reset then start_i=1, imem returns 0x00A00093 at 0, 0x00108113 at 4 -> pc_o 0,4,8; id_instr_o 0x13(valid 0), 0x00A00093(id_pc 0, valid 1), 0x00108113(id_pc 4); fetch_cnt_o 0,1,2.
- Running at pc=8, stall_i=1 for 3 cycles -> pc_o stays 8; id_pc_o/id_instr_o/id_valid_o frozen; fetch_cnt_o unchanged. Release -> pc 12 next edge.
- pc=0x10, redirect_i=1, redirect_pc_i=0x43 with stall_i=1 -> next cycle pc_o=0x40, id_valid_o=0, id_instr_o=0x13; following edge captures instruction at 0x40 with id_pc_o=0x40.
- flush_i=1 at pc=0x20 without stall -> pc_o=0x24, id_valid_o=0, fetch_cnt_o not incremented.
- start_i=0 for 2 cycles at pc=0x8 -> pc_o holds 0x8, bubbles in IF/ID. start_i=1 -> captures instruction at 0x8.
- XLEN=32, redirect to 0xFFFFFFFC, run 2 cycles -> pc_o 0xFFFFFFFC then 0x00000000. CNT_W=2: after 5 captures fetch_cnt_o=3. rst_i mid-stall -> all reset values next cycle.

Source files
------------

// File: rtl/if_stage_pipe.sv
// ----------------------------------------------------------------------------
// if_stage_pipe
//
// Instruction-fetch stage of the pipelined RISC-V CPU. One block holds the PC
// register, the PC+step incrementer and the IF/ID pipeline register. It also
// handles fetch enable, decode stall, flush, branch redirect and a saturating
// count of fetched instructions.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   start_i        fetch enable; low freezes the PC and feeds bubbles to decode
//   stall_i        decode hazard stall; holds the PC and IF/ID
//   flush_i        squash IF/ID (bubble); the PC path is unaffected
//   redirect_i     taken branch/jump; load redirect_pc_i and squash IF/ID
//   redirect_pc_i  redirect target (forced to PC_STEP alignment)
//   imem_addr_o    instruction-memory address, wire copy of the PC register
//   imem_instr_i   instruction word at imem_addr_o (combinational memory)
//   pc_o           current PC register
//   id_pc_o        PC of the instruction in IF/ID
//   id_instr_o     instruction in IF/ID (NOP_INSTR when it holds a bubble)
//   id_valid_o     IF/ID holds a real instruction
//   fetch_cnt_o    saturating count of instructions captured into IF/ID
// ----------------------------------------------------------------------------
module if_stage_pipe #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              PC_STEP   = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013),
    parameter int              CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic [XLEN-1:0]  imem_instr_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  id_pc_o,
    output logic [XLEN-1:0]  id_instr_o,
    output logic             id_valid_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    // Clears the low log2(PC_STEP) bits of a redirect target.
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~(XLEN'(PC_STEP - 1));
    localparam logic [XLEN-1:0]  STEP       = XLEN'(PC_STEP);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [XLEN-1:0]  pc_q,       pc_d;
    logic [XLEN-1:0]  id_pc_q,    id_pc_d;
    logic [XLEN-1:0]  id_instr_q, id_instr_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // PC next value: redirect beats stall; stall and a disabled fetch both
    // hold; otherwise step forward, wrapping silently at the top of memory.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ALIGN_MASK;
        end else if (stall_i || !start_i) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + STEP;
        end
    end

    // IF/ID next value. Flush and redirect squash even when stalled, so a
    // stalled-but-squashed slot becomes a bubble rather than holding. The
    // counter only moves on a genuine capture and sticks at its maximum.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        cnt_d      = cnt_q;
        if (flush_i || redirect_i) begin
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (stall_i) begin
            id_pc_d    = id_pc_q;
            id_instr_d = id_instr_q;
            id_valid_d = id_valid_q;
        end else if (!start_i) begin
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else begin
            id_pc_d    = pc_q;
            id_instr_d = imem_instr_i;
            id_valid_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards everything, including a pending stall
    // or redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign id_pc_o     = id_pc_q;
    assign id_instr_o  = id_instr_q;
    assign id_valid_o  = id_valid_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_stage_pipe.sv
// ----------------------------------------------------------------------------
// tb_if_stage_pipe
//
// Bench for if_stage_pipe (XLEN=32, PC_STEP=4, CNT_W=2). A combinational
// instruction memory answers the DUT's address. A behavioural model of the
// fetch stage is advanced on every rising edge and compared against all DUT
// outputs on every falling edge; a directed sequence pins the model with
// literal values before a long randomised run.
// ----------------------------------------------------------------------------
module tb_if_stage_pipe;

    localparam int          XLEN    = 32;
    localparam int          CNT_W   = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic             stall_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             redirect_i = 1'b0;
    logic [XLEN-1:0]  redirect_pc_i = '0;
    logic [XLEN-1:0]  imem_addr_o;
    logic [XLEN-1:0]  imem_instr_i;
    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  id_pc_o;
    logic [XLEN-1:0]  id_instr_o;
    logic             id_valid_o;
    logic [CNT_W-1:0] fetch_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model of the stage's visible state.
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_id_valid;
    int          m_cnt;
    bit          m_known = 1'b0;

    if_stage_pipe #(
        .XLEN      (XLEN),
        .RESET_PC  (32'h0),
        .PC_STEP   (4),
        .NOP_INSTR (32'h00000013),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .pc_o          (pc_o),
        .id_pc_o       (id_pc_o),
        .id_instr_o    (id_instr_o),
        .id_valid_o    (id_valid_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    // Memory contents: two fixed words at the start, a scrambled address
    // pattern everywhere else so each fetched word identifies its address.
    function automatic logic [31:0] instr_at(input logic [31:0] addr);
        if (addr == 32'h0)      return 32'h00A00093;
        else if (addr == 32'h4) return 32'h00108113;
        else                    return (addr * 32'h9E3779B1) ^ 32'h01234567;
    endfunction

    assign imem_instr_i = instr_at(imem_addr_o);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update from the fetch-stage rules, evaluated at each rising edge.
    always @(posedge clk) begin
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (rst_i) begin
            m_pc       = 32'h0;
            m_id_pc    = 32'h0;
            m_id_instr = NOP;
            m_id_valid = 1'b0;
            m_cnt      = 0;
            m_known    = 1'b1;
        end else begin
            if (redirect_i)             m_pc = {redirect_pc_i[31:2], 2'b00};
            else if (stall_i || !start_i) m_pc = old_pc;
            else                        m_pc = old_pc + 32'd4;

            if (flush_i || redirect_i || (!stall_i && !start_i)) begin
                m_id_pc    = 32'h0;
                m_id_instr = NOP;
                m_id_valid = 1'b0;
            end else if (!stall_i) begin
                m_id_pc    = old_pc;
                m_id_instr = instr_at(old_pc);
                m_id_valid = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
        end
    end

    // Compare process: every falling edge once the model state is defined.
    always @(negedge clk) begin
        if (m_known) begin
            checkOutput("pc_o",        pc_o,                  m_pc);
            checkOutput("imem_addr_o", imem_addr_o,           m_pc);
            checkOutput("id_pc_o",     id_pc_o,               m_id_pc);
            checkOutput("id_instr_o",  id_instr_o,            m_id_instr);
            checkOutput("id_valid_o",  {31'b0, id_valid_o},   {31'b0, m_id_valid});
            checkOutput("fetch_cnt_o", {30'b0, fetch_cnt_o},  32'(m_cnt));
        end
    end

    // Drive one set of inputs across the next rising edge and return just
    // after it, so the registered outputs already show the result.
    task automatic applyStimulus(input logic rst, input logic start, input logic stall,
                                 input logic flush, input logic redir,
                                 input logic [31:0] target);
        rst_i         = rst;
        start_i       = start;
        stall_i       = stall;
        flush_i       = flush;
        redirect_i    = redir;
        redirect_pc_i = target;
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [31:0] pc,
                              input logic [31:0] id_pc, input logic [31:0] instr,
                              input logic valid, input int cnt);
        checkOutput({tag, ".pc"},    pc_o,                 pc);
        checkOutput({tag, ".idpc"},  id_pc_o,              id_pc);
        checkOutput({tag, ".instr"}, id_instr_o,           instr);
        checkOutput({tag, ".valid"}, {31'b0, id_valid_o},  {31'b0, valid});
        checkOutput({tag, ".cnt"},   {30'b0, fetch_cnt_o}, 32'(cnt));
    endtask

    initial begin
        // Sequential fetch from reset.
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkState("rst", 32'h0, 32'h0, NOP, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkState("fetch0", 32'h4, 32'h0, 32'h00A00093, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkState("fetch1", 32'h8, 32'h4, 32'h00108113, 1, 2);

        // Stall for three cycles at pc=8, then release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 0);
            checkState("stall", 32'h8, 32'h4, 32'h00108113, 1, 2);
        end
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkState("unstall", 32'hC, 32'h8, instr_at(32'h8), 1, 3);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkState("sat", 32'h10, 32'hC, instr_at(32'hC), 1, 3);

        // Redirect together with stall: redirect wins, one bubble.
        applyStimulus(0, 1, 1, 0, 1, 32'h43);
        checkState("redir", 32'h40, 32'h0, NOP, 0, 3);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkState("redir_tgt", 32'h44, 32'h40, instr_at(32'h40), 1, 3);

        // Flush alone: PC advances, no capture.
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 32'h20);
        checkState("to20", 32'h20, 32'h0, NOP, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkState("flush", 32'h24, 32'h0, NOP, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkState("postflush", 32'h28, 32'h24, instr_at(32'h24), 1, 1);

        // Fetch disabled for two cycles at pc=8.
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkState("nostart", 32'h8, 32'h0, NOP, 0, 2);
        end
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkState("restart", 32'hC, 32'h8, instr_at(32'h8), 1, 3);

        // Wrap at the top of the address space; five captures saturate.
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 32'hFFFFFFFF);
        checkState("top", 32'hFFFFFFFC, 32'h0, NOP, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkState("wrap", 32'h0, 32'hFFFFFFFC, instr_at(32'hFFFFFFFC), 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkState("five", 32'h10, 32'hC, instr_at(32'hC), 1, 3);

        // Reset in the middle of a stall.
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 32'h80);
        checkState("rst_stall", 32'h0, 32'h0, NOP, 0, 0);

        // Randomised run, checked by the compare process every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = tgt | 32'hFFFFFF00;
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 7) != 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) == 0,
                          tgt);
        end

        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
